// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: flag register, condition evaluation, 2-bit predictor training and mispredict flush/redirect
module branch_resolve_unit #(
  parameter int PC_WIDTH = 16,
  parameter int BHT_IDX_BITS = 4,
  parameter logic [1:0] COUNTER_INIT = 2'b01,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flags_we,
  input  logic [3:0]          flags_in,
  output logic [3:0]          flags_q,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_taken,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [3:0]          br_cond,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                br_pred_taken,
  output logic                res_valid,
  output logic                res_taken,
  output logic                res_mispredict,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic [15:0]         mispred_count
);
  localparam int NE = 1 << BHT_IDX_BITS;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NE-1:0][1:0] bht_q, bht_d;
  logic [3:0] f;
  logic [15:0] ev;
  logic [1:0] ctr;
  logic [BHT_IDX_BITS-1:0] bidx;
  logic lt, taken, accept, mis, unused_pc;
  logic res_valid_d, res_taken_d, res_mispredict_d;
  logic [PC_WIDTH-1:0] redirect_pc_d;
  logic [15:0] mispred_count_d;
  assign unused_pc = ^pred_pc;
  assign f = flags_we ? flags_in : flags_q;
  assign lt = f[3] ^ f[0];
  assign ev = {~f[1] | f[2], f[1] & ~f[2], f[2] | lt, ~f[2] & ~lt, ~lt, lt,
               ~f[3], f[3], ~f[2], f[2], ~f[1], f[1], ~f[0], f[0], 2'b01};
  assign taken = ev[br_cond];
  assign br_ready = ~reset & (state_q == IDLE);
  assign flush = ~reset & (state_q == FLUSH);
  assign accept = br_valid & br_ready;
  assign mis = taken ^ br_pred_taken;
  assign bidx = br_pc[BHT_IDX_BITS-1:0];
  assign ctr = bht_q[bidx];
  assign pred_taken = bht_q[pred_pc[BHT_IDX_BITS-1:0]][1];
  always_comb begin
    bht_d = bht_q;
    if (accept && br_cond > 4'd1)
      bht_d[bidx] = taken ? ctr + 2'(ctr != 2'd3) : ctr - 2'(ctr != 2'd0);
    res_valid_d = accept;
    res_taken_d = accept & taken;
    res_mispredict_d = accept & mis;
    redirect_pc_d = accept ? (taken ? br_target : br_pc + PC_WIDTH'(1)) : redirect_pc;
    mispred_count_d = mispred_count + 16'(res_mispredict_d && mispred_count != 16'hFFFF);
    state_d = (state_q == FLUSH) ? (cnt_q == CW'(1) ? IDLE : FLUSH) : (res_mispredict_d ? FLUSH : IDLE);
    cnt_d = (state_q == FLUSH) ? cnt_q - CW'(1) : CW'(FLUSH_CYCLES);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      bht_q <= {NE{COUNTER_INIT}};
      state_q <= IDLE;
      cnt_q <= '0;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_mispredict <= 1'b0;
      redirect_pc <= '0;
      mispred_count <= '0;
    end else begin
      flags_q <= f;
      bht_q <= bht_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_valid <= res_valid_d;
      res_taken <= res_taken_d;
      res_mispredict <= res_mispredict_d;
      redirect_pc <= redirect_pc_d;
      mispred_count <= mispred_count_d;
    end
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised branch resolution stage for the CPU datapath.
- Holds the architectural flag register (V, C, Z, N) and evaluates a 4-bit condition code against it, including negated and compound signed/unsigned conditions.
- Trains a direct-mapped table of 2-bit saturating predictors.
- Flags mispredictions and drives a timed pipeline flush plus a redirect PC back to fetch.

Parameters:
PC_WIDTH, 16, width of PC and target addresses (word-addressed).
BHT_IDX_BITS, 4, predictor table has 2^BHT_IDX_BITS entries, indexed by PC[BHT_IDX_BITS-1:0].
COUNTER_INIT, 2'b01, reset value of every predictor counter (weakly not-taken).
FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict (≥1).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flags_we  in  1  write flags_in into flag register
flags_in  in  4  new flags: [0]=V overflow, [1]=C carry, [2]=Z zero, [3]=N negative
flags_q  out  4  current flag register
pred_pc  in  PC_WIDTH  fetch PC for prediction lookup
pred_taken  out  1  combinational: MSB of counter at pred_pc index
br_valid  in  1  branch presented for resolution
br_ready  out  1  unit can accept a branch this cycle
br_cond  in  4  condition code
br_pc  in  PC_WIDTH  PC of branch instruction
br_target  in  PC_WIDTH  taken target
br_pred_taken  in  1  prediction used at fetch
res_valid  out  1  one-cycle pulse: result outputs valid
res_taken  out  1  resolved outcome
res_mispredict  out  1  res_taken != captured br_pred_taken
redirect_pc  out  PC_WIDTH  correct next PC
flush  out  1  squash younger pipeline stages
mispred_count  out  16  saturating mispredict counter

Behaviour:
- Reset (synchronous, sampled at a rising edge with reset=1):
  - flags_q=0; all counters=COUNTER_INIT; state=IDLE.
  - res_valid, res_taken, res_mispredict, flush = 0; redirect_pc=0; mispred_count=0.
  - br_ready=0 while reset is high, 1 in the first cycle after release.
- Reset mid-flush aborts the flush immediately; no pending result is emitted.
- Flag register: flags_q <= flags_in on flags_we.
- Evaluation uses effective flags F = flags_we ? flags_in : flags_q (same-cycle bypass).
- Condition codes:
  - 0 always; 1 never.
  - 2 V; 3 !V; 4 C; 5 !C; 6 Z; 7 !Z; 8 N; 9 !N.
  - 10 N^V (signed lt); 11 !(N^V) (signed ge).
  - 12 !Z & !(N^V) (signed gt); 13 Z | (N^V) (signed le).
  - 14 C & !Z (unsigned higher); 15 !C | Z (unsigned lower-or-same).
- Accept = br_valid & br_ready.
- Latency: accept in cycle T; in cycle T+1:
  - res_valid=1 for exactly one cycle, with res_taken, res_mispredict, redirect_pc valid.
  - Outputs are registered; they are 0 / hold don't-care when res_valid=0.
- redirect_pc:
  - taken → br_target.
  - not taken → br_pc+1, modulo 2^PC_WIDTH (all-ones PC wraps to 0).
- Predictor update:
  - Only for cond 2..15, at the edge ending cycle T.
  - Counter at br_pc index: taken → increment, saturating at 3; not taken → decrement, saturating at 0.
  - Codes 0/1 never touch the table.
  - pred_taken read of the same index in cycle T returns the old value; in T+1, the new value.
- State machine:
  - IDLE: br_ready=1. Accept with correct prediction stays in IDLE, so back-to-back branches run at one per cycle. Accept with mispredict goes to FLUSH with cnt=FLUSH_CYCLES.
  - FLUSH: flush=1 and br_ready=0 for FLUSH_CYCLES cycles (T+1 .. T+FLUSH_CYCLES). br_valid is ignored, with no side effects. cnt decrements each cycle; return to IDLE when it reaches 1.
- mispred_count increments on each res_mispredict pulse and saturates at 0xFFFF.
- flags_we is honoured in every state, including FLUSH.

Test Plan:
- Reset with flags_in=4'hF pending → flags_q=0, pred_taken=0 for all pred_pc, br_ready=1 the cycle after release, mispred_count=0.
- flags_q=4'b0100 (Z), cond=6, br_pc=0x0010, target=0x0200, pred=1 → T+1: res_valid=1, res_taken=1, mispredict=0, redirect=0x0200, flush=0; next branch accepted in T+1.
- Same-cycle bypass: flags_q=0, flags_we=1, flags_in=4'b1000 (N), cond=10 (N^V), pred=0 → res_taken=1, mispredict=1, flush high exactly 2 cycles, br_ready=0 in both; br_valid during flush yields no res_valid; mispred_count=1.
- Predictor training: three taken cond=4 branches at PC 0x0003 with C=1 → counter 01→10→11→11, pred_taken(0x0003)=1 from the cycle after the first update; cond=0 at PC 0x0013 leaves counter unchanged.
- Wrap: cond=1 (never), br_pc=0xFFFF, pred=0 → res_taken=0, redirect_pc=0x0000, no mispredict; cond=15 with C=1, Z=0 → not taken.
- Reset asserted in the first flush cycle → flush=0 and br_ready=0 during reset, state IDLE after release, no further res_valid.
